// File: rtl/dvid2vga_pkg.sv
// Shared constants and types for the dvid2vga TMDS receiver.
// Holds the control-token table, symbol width and alignment FSM encoding.
package dvid2vga_pkg;

    localparam int SYM_W = 10;

    // Control tokens indexed by C1C0.
    localparam logic [SYM_W-1:0] CTRL_TOK_00 = 10'h354;
    localparam logic [SYM_W-1:0] CTRL_TOK_01 = 10'h0AB;
    localparam logic [SYM_W-1:0] CTRL_TOK_10 = 10'h154;
    localparam logic [SYM_W-1:0] CTRL_TOK_11 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_t;

    function automatic logic is_ctrl_tok(input logic [SYM_W-1:0] s);
        return (s == CTRL_TOK_00) || (s == CTRL_TOK_01) ||
               (s == CTRL_TOK_10) || (s == CTRL_TOK_11);
    endfunction

endpackage

// File: rtl/tmds_decode_ch.sv
// One TMDS receive channel: input register, symbol decoder and the word
// alignment FSM that requests bitslips from the external deserializer.
module tmds_decode_ch
    import dvid2vga_pkg::*;
#(
    parameter int c_search_win = 4096,
    parameter int c_ctrl_run   = 8,
    parameter int c_slip_wait  = 16
) (
    input  logic             clk_pixel,
    input  logic             resetq,
    input  logic [SYM_W-1:0] sym,
    output logic             de,
    output logic [1:0]       c,
    output logic [7:0]       data,
    output logic             bitslip,
    output align_state_t     state
);

    localparam int WIN_W  = $clog2(c_search_win + 1);
    localparam int RUN_W  = $clog2(c_ctrl_run + 1);
    localparam int SLIP_W = $clog2(c_slip_wait + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(c_search_win - 1);
    localparam logic [RUN_W-1:0]  RUN_DONE  = RUN_W'(c_ctrl_run);
    localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(c_slip_wait - 1);

    logic [SYM_W-1:0]  sym_q;
    logic [7:0]        d;
    logic [WIN_W-1:0]  win;
    logic [RUN_W-1:0]  run;
    logic [RUN_W-1:0]  run_nxt;
    logic [SLIP_W-1:0] slip_cnt;
    logic              raw_ctrl;
    logic              run_done;

    always_ff @(posedge clk_pixel or negedge resetq) begin
        if (!resetq) sym_q <= CTRL_TOK_00;
        else         sym_q <= sym;
    end

    always_comb begin
        d    = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
        data = '0;
        data[0] = d[0];
        for (int i = 1; i < 8; i++)
            data[i] = sym_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        de = !is_ctrl_tok(sym_q);
        case (sym_q)
            CTRL_TOK_01: c = 2'b01;
            CTRL_TOK_10: c = 2'b10;
            CTRL_TOK_11: c = 2'b11;
            default:     c = 2'b00;
        endcase
    end

    // Alignment looks at the raw symbol so the run counter itself acts as the
    // first pipeline register of the lock path.
    assign raw_ctrl = is_ctrl_tok(sym);

    always_comb begin
        run_nxt = '0;
        if (raw_ctrl) run_nxt = (run == RUN_DONE) ? run : run + 1'b1;
    end

    assign run_done = (run_nxt == RUN_DONE);

    always_ff @(posedge clk_pixel or negedge resetq) begin
        if (!resetq) begin
            state    <= ST_SEARCH;
            run      <= '0;
            win      <= '0;
            slip_cnt <= '0;
            bitslip  <= 1'b0;
        end else begin
            bitslip <= 1'b0;
            case (state)
                ST_SEARCH: begin
                    run <= run_nxt;
                    if (run_done) begin
                        state <= ST_LOCKED;
                        win   <= '0;
                    end else if (win == WIN_LAST) begin
                        state    <= ST_SLIP;
                        bitslip  <= 1'b1;
                        win      <= '0;
                        run      <= '0;
                        slip_cnt <= '0;
                    end else begin
                        win <= win + 1'b1;
                    end
                end
                ST_SLIP: begin
                    if (slip_cnt == SLIP_LAST) begin
                        state <= ST_SEARCH;
                        run   <= '0;
                        win   <= '0;
                    end else begin
                        slip_cnt <= slip_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    run <= run_nxt;
                    if (run_done) begin
                        win <= '0;
                    end else if (win == WIN_LAST) begin
                        state <= ST_SEARCH;
                        win   <= '0;
                        run   <= '0;
                    end else begin
                        win <= win + 1'b1;
                    end
                end
                default: state <= ST_SEARCH;
            endcase
        end
    end

endmodule

// File: rtl/dvid2vga.sv
// DVI receive decoder: three aligned TMDS channels back to VGA-style signals.
// Define DVID2VGA_ERRCNT_EN to build the inter-channel disagreement counter.
module dvid2vga
    import dvid2vga_pkg::*;
#(
    parameter int c_search_win = 4096,
    parameter int c_ctrl_run   = 8,
    parameter int c_slip_wait  = 16
) (
    input  logic             clk_pixel,
    input  logic             resetq,
    input  logic [SYM_W-1:0] in_blue,
    input  logic [SYM_W-1:0] in_green,
    input  logic [SYM_W-1:0] in_red,
    output logic [2:0]       bitslip,
    output logic             locked,
    output logic [7:0]       vga_r,
    output logic [7:0]       vga_g,
    output logic [7:0]       vga_b,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic             vga_blank,
    output logic [15:0]      err_count
);

    // Symbols arrive every cycle; there is no valid/ready handshake anywhere.
    logic [SYM_W-1:0] ch_sym   [3];
    logic [1:0]       ch_c     [3];
    logic [7:0]       ch_data  [3];
    align_state_t     ch_state [3];
    logic [2:0]       ch_de;
    logic             all_locked;
    logic             unused_sigs;

    assign ch_sym[0] = in_blue;
    assign ch_sym[1] = in_green;
    assign ch_sym[2] = in_red;

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        tmds_decode_ch #(
            .c_search_win (c_search_win),
            .c_ctrl_run   (c_ctrl_run),
            .c_slip_wait  (c_slip_wait)
        ) u_ch (
            .clk_pixel (clk_pixel),
            .resetq    (resetq),
            .sym       (ch_sym[ch]),
            .de        (ch_de[ch]),
            .c         (ch_c[ch]),
            .data      (ch_data[ch]),
            .bitslip   (bitslip[ch]),
            .state     (ch_state[ch])
        );
    end

    assign all_locked = (ch_state[0] == ST_LOCKED) && (ch_state[1] == ST_LOCKED) &&
                        (ch_state[2] == ST_LOCKED);

    // Sync and blank follow the blue channel only; green/red control bits are unused.
    assign unused_sigs = ^{ch_c[1], ch_c[2], ch_de[2:1]};

    always_ff @(posedge clk_pixel or negedge resetq) begin
        if (!resetq) begin
            locked    <= 1'b0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            vga_hsync <= 1'b0;
            vga_vsync <= 1'b0;
            vga_blank <= 1'b1;
        end else begin
            locked <= all_locked;
            if (!locked) begin
                vga_r     <= '0;
                vga_g     <= '0;
                vga_b     <= '0;
                vga_hsync <= 1'b0;
                vga_vsync <= 1'b0;
                vga_blank <= 1'b1;
            end else if (!ch_de[0]) begin
                vga_r     <= '0;
                vga_g     <= '0;
                vga_b     <= '0;
                vga_hsync <= ch_c[0][0];
                vga_vsync <= ch_c[0][1];
                vga_blank <= 1'b1;
            end else begin
                vga_r     <= ch_data[2];
                vga_g     <= ch_data[1];
                vga_b     <= ch_data[0];
                vga_blank <= 1'b0;
            end
        end
    end

`ifdef DVID2VGA_ERRCNT_EN
    logic ch_disagree;

    assign ch_disagree = (|ch_de) && !(&ch_de);

    always_ff @(posedge clk_pixel or negedge resetq) begin
        if (!resetq)
            err_count <= '0;
        else if (locked && ch_disagree && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_dvid2vga.sv
// Self-checking bench for dvid2vga: lock, sync/blank, data decode round trip,
// bitslip realignment, lock loss, reset during a slip and the error counter.
module tb_dvid2vga;

    localparam int W = 4096;
    localparam int C = 8;
    localparam int S = 16;
    localparam logic [9:0] T00 = 10'h354;
    localparam logic [9:0] T01 = 10'h0AB;
    localparam logic [9:0] T10 = 10'h154;
    localparam logic [9:0] T11 = 10'h2AB;
    localparam logic [9:0] DAT = 10'h1FF;

    logic        clk_pixel = 1'b0;
    logic        resetq    = 1'b0;
    logic [9:0]  in_blue   = T00;
    logic [9:0]  in_green  = T00;
    logic [9:0]  in_red    = T00;
    logic [2:0]  bitslip;
    logic        locked;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, vga_blank;
    logic [15:0] err_count;

    int          checks = 0;
    int          errors = 0;
    int          disp[3];
    logic [26:0] exp_q[$];
    logic        m_hs, m_vs;

    dvid2vga dut (
        .clk_pixel (clk_pixel),
        .resetq    (resetq),
        .in_blue   (in_blue),
        .in_green  (in_green),
        .in_red    (in_red),
        .bitslip   (bitslip),
        .locked    (locked),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_blank (vga_blank),
        .err_count (err_count)
    );

    always #4 clk_pixel = ~clk_pixel;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    function automatic logic [9:0] tok_of(input int cc);
        case (cc)
            0:       return T00;
            1:       return T01;
            2:       return T10;
            default: return T11;
        endcase
    endfunction

    function automatic bit is_tok(input logic [9:0] s);
        for (int i = 0; i < 4; i++) if (s == tok_of(i)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] ctl_of(input logic [9:0] s);
        for (int i = 0; i < 4; i++) if (s == tok_of(i)) return 2'(i);
        return 2'b00;
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] q);
        logic [7:0] dd, o;
        bit x;
        dd = q[9] ? ~q[7:0] : q[7:0];
        o[0] = dd[0];
        for (int i = 1; i < 8; i++) begin
            x = dd[i] ^ dd[i-1];
            o[i] = q[8] ? x : !x;
        end
        return o;
    endfunction

    // DVI 1.0 TMDS encoder with per-channel running disparity.
    function automatic logic [9:0] tmds_enc(input int ch, input logic [7:0] v);
        logic [8:0] qm;
        logic [9:0] q;
        int n1v, n1q, n0q;
        n1v = $countones(v);
        qm[0] = v[0];
        if (n1v > 4 || (n1v == 4 && !v[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ v[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ v[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (disp[ch] == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            disp[ch] += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((disp[ch] > 0 && n1q > n0q) || (disp[ch] < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            disp[ch] += (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            disp[ch] += (qm[8] ? 0 : -2) + n1q - n0q;
        end
        return q;
    endfunction

    function automatic logic [9:0] rot(input logic [9:0] s, input int n);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = s[(i + n) % 10];
        return r;
    endfunction

    task automatic idle_cycle(input logic [9:0] b, input logic [9:0] g, input logic [9:0] r);
        @(negedge clk_pixel);
        in_blue = b; in_green = g; in_red = r;
        @(posedge clk_pixel); #1;
    endtask

    // Drives one symbol triple and checks the outputs owed from the previous one.
    task automatic sb_cycle(input logic [9:0] b, input logic [9:0] g, input logic [9:0] r,
                            input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        logic [26:0] e;
        @(negedge clk_pixel);
        in_blue = b; in_green = g; in_red = r;
        if (is_tok(b)) begin
            {m_vs, m_hs} = ctl_of(b);
            e = {1'b1, m_hs, m_vs, 24'h0};
        end else begin
            e = {1'b0, m_hs, m_vs, er, eg, eb};
        end
        exp_q.push_back(e);
        @(posedge clk_pixel); #1;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            checks++;
            if ({vga_blank, vga_hsync, vga_vsync, vga_r, vga_g, vga_b} !== e) begin
                errors++;
                $display("FAIL pipe: got %h expected %h",
                         {vga_blank, vga_hsync, vga_vsync, vga_r, vga_g, vga_b}, e);
            end
        end
    endtask

    task automatic test_reset;
        resetq = 1'b0;
        in_blue = T00; in_green = T00; in_red = T00;
        repeat (3) @(posedge clk_pixel);
        #1;
        checks++; if (bitslip !== 3'b000) begin errors++; $display("FAIL rst_bitslip: got %b expected 000", bitslip); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b expected 0", locked); end
        checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin errors++; $display("FAIL rst_rgb: got %h expected 0", {vga_r, vga_g, vga_b}); end
        checks++; if (vga_hsync !== 1'b0 || vga_vsync !== 1'b0) begin errors++; $display("FAIL rst_sync: got %b%b expected 00", vga_hsync, vga_vsync); end
        checks++; if (vga_blank !== 1'b1) begin errors++; $display("FAIL rst_blank: got %b expected 1", vga_blank); end
        checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL rst_err: got %h expected 0", err_count); end
        @(negedge clk_pixel);
        resetq = 1'b1;
        for (int k = 1; k <= C + 1; k++) begin
            @(posedge clk_pixel); #1;
            checks++;
            if (bitslip !== 3'b000) begin errors++; $display("FAIL idle_bitslip: got %b expected 000 at cycle %0d", bitslip, k); end
            if (k == C) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b expected 0 at cycle %0d", locked, k); end
            end
            if (k == C + 1) begin
                checks++;
                if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b expected 1 at cycle %0d", locked, k); end
            end
        end
        checks++;
        if ({vga_blank, vga_hsync, vga_vsync} !== 3'b100) begin
            errors++; $display("FAIL idle_outputs: got %b expected 100", {vga_blank, vga_hsync, vga_vsync});
        end
    endtask

    task automatic test_sync;
        exp_q.delete();
        m_hs = 1'b0; m_vs = 1'b0;
        repeat (20) sb_cycle(T11, T00, T00, 8'h0, 8'h0, 8'h0);
        repeat (6) sb_cycle(DAT, DAT, DAT, ref_decode(DAT), ref_decode(DAT), ref_decode(DAT));
        checks++;
        if ({vga_blank, vga_hsync, vga_vsync} !== 3'b011) begin
            errors++; $display("FAIL sync_hold: got %b expected 011", {vga_blank, vga_hsync, vga_vsync});
        end
        checks++;
        if (vga_r !== ref_decode(DAT)) begin errors++; $display("FAIL data_1ff: got %h expected %h", vga_r, ref_decode(DAT)); end
        repeat (12) sb_cycle(T00, T00, T00, 8'h0, 8'h0, 8'h0);
        exp_q.delete();
    endtask

    task automatic test_data_decode;
        logic [7:0] tbl[4];
        logic [7:0] vr, vg, vb;
        tbl[0] = 8'h00; tbl[1] = 8'h55; tbl[2] = 8'hA5; tbl[3] = 8'hFF;
        disp[0] = 0; disp[1] = 0; disp[2] = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            vr = tbl[i % 4]; vg = tbl[(i + 1) % 4]; vb = tbl[(i + 2) % 4];
            sb_cycle(tmds_enc(0, vb), tmds_enc(1, vg), tmds_enc(2, vr), vr, vg, vb);
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                sb_cycle(tok_of($urandom_range(0, 3)), tok_of($urandom_range(0, 3)),
                         tok_of($urandom_range(0, 3)), 8'h0, 8'h0, 8'h0);
            end else begin
                vr = 8'($urandom_range(0, 255));
                vg = 8'($urandom_range(0, 255));
                vb = 8'($urandom_range(0, 255));
                sb_cycle(tmds_enc(0, vb), tmds_enc(1, vg), tmds_enc(2, vr), vr, vg, vb);
            end
        end
        repeat (12) sb_cycle(T00, T00, T00, 8'h0, 8'h0, 8'h0);
        exp_q.delete();
        checks++;
        if (err_count !== 16'h0) begin errors++; $display("FAIL err_agree: got %h expected 0", err_count); end
    endtask

    task automatic test_realign;
        int start_off, off, cyc, lock_at, exp_slips;
        int slip_at[$];
        bit side;
        start_off = 7;
        off = start_off;
        exp_slips = (10 - start_off) % 10;
        cyc = 0; lock_at = -1; side = 1'b0;
        @(negedge clk_pixel);
        resetq = 1'b0;
        in_blue = T00; in_green = T00; in_red = rot(T00, off);
        repeat (2) @(posedge clk_pixel);
        @(negedge clk_pixel);
        resetq = 1'b1;
        while (cyc < 4 * (W + S) + 200 && lock_at < 0) begin
            @(posedge clk_pixel); #1;
            cyc++;
            if (bitslip[1:0] != 2'b00) side = 1'b1;
            if (bitslip[2]) begin
                slip_at.push_back(cyc);
                off = (off + 1) % 10;
            end
            if (locked) lock_at = cyc;
            @(negedge clk_pixel);
            in_red = rot(T00, off);
        end
        checks++; if (lock_at < 0) begin errors++; $display("FAIL realign_timeout: got no lock expected lock"); end
        checks++; if (slip_at.size() != exp_slips) begin errors++; $display("FAIL slip_count: got %0d expected %0d", slip_at.size(), exp_slips); end
        checks++; if (side) begin errors++; $display("FAIL side_slip: got 1 expected 0"); end
        if (slip_at.size() >= 3) begin
            checks++; if (slip_at[0] != W) begin errors++; $display("FAIL slip_first: got %0d expected %0d", slip_at[0], W); end
            checks++; if (slip_at[1] - slip_at[0] != W + S) begin errors++; $display("FAIL slip_period1: got %0d expected %0d", slip_at[1] - slip_at[0], W + S); end
            checks++; if (slip_at[2] - slip_at[1] != W + S) begin errors++; $display("FAIL slip_period2: got %0d expected %0d", slip_at[2] - slip_at[1], W + S); end
            checks++; if (lock_at - slip_at[2] != S + C + 1) begin errors++; $display("FAIL relock_delay: got %0d expected %0d", lock_at - slip_at[2], S + C + 1); end
        end
    endtask

    task automatic test_loss_and_reset;
        int n;
        repeat (12) idle_cycle(T00, T00, T00);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL pre_loss_lock: got %b expected 1", locked); end
        for (int k = 1; k <= W + 3; k++) begin
            idle_cycle(DAT, DAT, DAT);
            if (k == W - 1) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_early: got %b expected 1", locked); end
            end
            if (k == W + 1) begin
                checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_drop: got %b expected 0", locked); end
            end
            if (k == W + 3) begin
                checks++;
                if ({vga_blank, vga_hsync, vga_vsync, vga_r, vga_g, vga_b} !== {3'b100, 24'h0}) begin
                    errors++; $display("FAIL loss_outputs: got %h expected %h",
                                       {vga_blank, vga_hsync, vga_vsync, vga_r, vga_g, vga_b}, {3'b100, 24'h0});
                end
            end
        end
        n = 0;
        while (n < W + 50 && bitslip === 3'b000) begin
            idle_cycle(DAT, DAT, DAT);
            n++;
        end
        checks++; if (bitslip !== 3'b111) begin errors++; $display("FAIL search_slip: got %b expected 111", bitslip); end
        resetq = 1'b0;
        #1;
        checks++; if (bitslip !== 3'b000) begin errors++; $display("FAIL reset_mid_slip: got %b expected 000", bitslip); end
        checks++; if (locked !== 1'b0 || vga_blank !== 1'b1) begin errors++; $display("FAIL reset_mid_state: got %b%b expected 01", locked, vga_blank); end
    endtask

    task automatic test_err_count;
        logic [15:0] exp_err;
`ifdef DVID2VGA_ERRCNT_EN
        exp_err = 16'd5;
`else
        exp_err = 16'd0;
`endif
        @(negedge clk_pixel);
        in_blue = T00; in_green = T00; in_red = T00;
        resetq = 1'b1;
        repeat (C + 4) idle_cycle(T00, T00, T00);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL err_lock: got %b expected 1", locked); end
        checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL err_start: got %h expected 0", err_count); end
        repeat (5) idle_cycle(T00, DAT, T00);
        repeat (4) idle_cycle(T00, T00, T00);
        checks++; if (err_count !== exp_err) begin errors++; $display("FAIL err_count: got %0d expected %0d", err_count, exp_err); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL err_keep_lock: got %b expected 1", locked); end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_data_decode();
        test_realign();
        test_loss_and_reset();
        test_err_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
